vedic_mult_pipe: RTL and testbench



---
 rtl/vedic_mult_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined Urdhva-Tiryagbhyam (Vedic) multiplier.
//   S1 registers operands/tag, S2 registers four half-width Vedic sub-products,
//   S3 combines them into the exact 2*WIDTH-bit product.
//   All stages advance together on adv = !(out_valid && !out_ready); bubbles
//   are kept, so latency is exactly 3 cycles with a free-running consumer.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready is combinational)
//   in_a, in_b           WIDTH-bit operands
//   in_signed            two's-complement mode (only with VEDIC_SIGNED_EN)
//   in_tag               sideband tag, returned on out_tag with its result
//   out_valid/out_ready  result handshake
//   out_product          exact 2*WIDTH-bit product
//   out_tag              tag of the current result
// Optional: define VEDIC_SIGNED_EN to add signed (sign-magnitude) support.
module vedic_mult_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int unsigned H     = WIDTH / 2;
   localparam int unsigned SP_W  = 2 * H;
   localparam int unsigned MID_W = SP_W + 1;
   localparam int unsigned P_W   = 2 * WIDTH;

   // Reject unsupported operand widths at elaboration
   generate
      if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
         $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("vedic_mult_pipe: TAG_W must be at least 1");
      end
   endgenerate

   // Global pipeline advance: only a stalled output blocks the pipe
   logic adv_c;
   logic out_valid_q;
   assign adv_c    = !(out_valid_q && !out_ready);
   assign in_ready = adv_c;

   // Operand conditioning ahead of S1
   logic [WIDTH-1:0] a_op_c;
   logic [WIDTH-1:0] b_op_c;
`ifdef VEDIC_SIGNED_EN
   logic sign_c;
   always_comb begin
      a_op_c = in_a;
      b_op_c = in_b;
      sign_c = 1'b0;
      if (in_signed) begin
         // -2^(W-1) negates to itself, which is the correct unsigned magnitude
         if (in_a[WIDTH-1]) a_op_c = ~in_a + WIDTH'(1);
         if (in_b[WIDTH-1]) b_op_c = ~in_b + WIDTH'(1);
         sign_c = in_a[WIDTH-1] ^ in_b[WIDTH-1];
      end
   end
`else
   logic unused_signed_c;
   assign a_op_c          = in_a;
   assign b_op_c          = in_b;
   assign unused_signed_c = in_signed;
`endif

   // Pipeline state
   logic             v1_q, v1_d;
   logic [WIDTH-1:0] a1_q, a1_d;
   logic [WIDTH-1:0] b1_q, b1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d;
   logic             v2_q, v2_d;
   logic [SP_W-1:0]  ll_q, ll_d, hl_q, hl_d, lh_q, lh_d, hh_q, hh_d;
   logic [TAG_W-1:0] tag2_q, tag2_d;
   logic             out_valid_d;
   logic [P_W-1:0]   out_product_q, out_product_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef VEDIC_SIGNED_EN
   logic             sign1_q, sign1_d;
   logic             sign2_q, sign2_d;
`endif

   // S2 sub-products from the registered S1 operand halves
   logic [SP_W-1:0] ll_c, hl_c, lh_c, hh_c;

   vedic_core #(.N(H)) u_ll (.a(a1_q[H-1:0]),     .b(b1_q[H-1:0]),     .p(ll_c));
   vedic_core #(.N(H)) u_hl (.a(a1_q[WIDTH-1:H]), .b(b1_q[H-1:0]),     .p(hl_c));
   vedic_core #(.N(H)) u_lh (.a(a1_q[H-1:0]),     .b(b1_q[WIDTH-1:H]), .p(lh_c));
   vedic_core #(.N(H)) u_hh (.a(a1_q[WIDTH-1:H]), .b(b1_q[WIDTH-1:H]), .p(hh_c));

   // S3 combine; middle sum keeps its carry
   logic [MID_W-1:0] mid_c;
   logic [P_W-1:0]   mag_c;
   logic [P_W-1:0]   prod_c;
   always_comb begin
      mid_c  = MID_W'(hl_q) + MID_W'(lh_q);
      mag_c  = P_W'(ll_q) + (P_W'(mid_c) << H) + (P_W'(hh_q) << WIDTH);
      prod_c = mag_c;
`ifdef VEDIC_SIGNED_EN
      if (sign2_q) prod_c = ~mag_c + P_W'(1);
`endif
   end

   // Next-state: all stages move together on adv, payloads load only with valid
   always_comb begin
      v1_d          = v1_q;
      a1_d          = a1_q;
      b1_d          = b1_q;
      tag1_d        = tag1_q;
      v2_d          = v2_q;
      ll_d          = ll_q;
      hl_d          = hl_q;
      lh_d          = lh_q;
      hh_d          = hh_q;
      tag2_d        = tag2_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      out_tag_d     = out_tag_q;
`ifdef VEDIC_SIGNED_EN
      sign1_d       = sign1_q;
      sign2_d       = sign2_q;
`endif
      if (adv_c) begin
         v1_d = in_valid;
         if (in_valid) begin
            a1_d   = a_op_c;
            b1_d   = b_op_c;
            tag1_d = in_tag;
`ifdef VEDIC_SIGNED_EN
            sign1_d = sign_c;
`endif
         end
         v2_d = v1_q;
         if (v1_q) begin
            ll_d   = ll_c;
            hl_d   = hl_c;
            lh_d   = lh_c;
            hh_d   = hh_c;
            tag2_d = tag1_q;
`ifdef VEDIC_SIGNED_EN
            sign2_d = sign1_q;
`endif
         end
         out_valid_d = v2_q;
         if (v2_q) begin
            out_product_d = prod_c;
            out_tag_d     = tag2_q;
         end
      end
   end

   // Pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q          <= 1'b0;
         a1_q          <= '0;
         b1_q          <= '0;
         tag1_q        <= '0;
         v2_q          <= 1'b0;
         ll_q          <= '0;
         hl_q          <= '0;
         lh_q          <= '0;
         hh_q          <= '0;
         tag2_q        <= '0;
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_tag_q     <= '0;
`ifdef VEDIC_SIGNED_EN
         sign1_q       <= 1'b0;
         sign2_q       <= 1'b0;
`endif
      end else begin
         v1_q          <= v1_d;
         a1_q          <= a1_d;
         b1_q          <= b1_d;
         tag1_q        <= tag1_d;
         v2_q          <= v2_d;
         ll_q          <= ll_d;
         hl_q          <= hl_d;
         lh_q          <= lh_d;
         hh_q          <= hh_d;
         tag2_q        <= tag2_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         out_tag_q     <= out_tag_d;
`ifdef VEDIC_SIGNED_EN
         sign1_q       <= sign1_d;
         sign2_q       <= sign2_d;
`endif
      end
   end

   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_tag     = out_tag_q;

endmodule

// vedic_core: combinational N x N Vedic multiplier, recursive down to 2x2 cells.
// Ports: a, b (N-bit operands), p (2N-bit product). N is a power of two >= 2.
module vedic_core #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);
   generate
      if (N == 2) begin : g_cell
         // 2x2 cell: cross terms and the top term reduced with half adders
         logic t1_c, t2_c, t3_c, c1_c;
         assign t1_c = a[1] & b[0];
         assign t2_c = a[0] & b[1];
         assign t3_c = a[1] & b[1];
         assign c1_c = t1_c & t2_c;
         assign p[0] = a[0] & b[0];
         assign p[1] = t1_c ^ t2_c;
         assign p[2] = t3_c ^ c1_c;
         assign p[3] = t3_c & c1_c;
      end else begin : g_split
         localparam int unsigned HN = N / 2;
         localparam int unsigned MN = N + 1;
         localparam int unsigned PN = 2 * N;
         logic [N-1:0] ll_c, hl_c, lh_c, hh_c;
         logic [N:0]   mid_c;
         vedic_core #(.N(HN)) u_ll (.a(a[HN-1:0]), .b(b[HN-1:0]), .p(ll_c));
         vedic_core #(.N(HN)) u_hl (.a(a[N-1:HN]), .b(b[HN-1:0]), .p(hl_c));
         vedic_core #(.N(HN)) u_lh (.a(a[HN-1:0]), .b(b[N-1:HN]), .p(lh_c));
         vedic_core #(.N(HN)) u_hh (.a(a[N-1:HN]), .b(b[N-1:HN]), .p(hh_c));
         assign mid_c = MN'(hl_c) + MN'(lh_c);
         assign p     = PN'(ll_c) + (PN'(mid_c) << HN) + (PN'(hh_c) << N);
      end
   endgenerate
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe (WIDTH=16, TAG_W=4): reset, single op,
// back-to-back stream, backpressure, async reset mid-flight, optional signed
// vectors, and a short randomized valid/ready stream against a queue model.
module tb_vedic_mult_pipe;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned P_W   = 2 * WIDTH;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [P_W-1:0]     out_product;
   logic [TAG_W-1:0]   out_tag;

   int checks = 0;
   int errors = 0;

   vedic_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_signed  (in_signed),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation with exact 3-cycle latency check
   task automatic run_single(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic sgn,
                             input logic [TAG_W-1:0] tag, input logic [P_W-1:0] exp);
      in_a = a; in_b = b; in_signed = sgn; in_tag = tag; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({name, "_lat1"}, 64'(out_valid), 64'd0);
      tick();
      check({name, "_lat2"}, 64'(out_valid), 64'd0);
      tick();
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_prod"}, 64'(out_product), 64'(exp));
      check({name, "_tag"}, 64'(out_tag), 64'(tag));
      tick();
      check({name, "_done"}, 64'(out_valid), 64'd0);
   endtask

   logic [WIDTH-1:0] st_a [4] = '{16'hFFFF, 16'h1234, 16'h0000, 16'h0001};
   logic [WIDTH-1:0] st_b [4] = '{16'hFFFF, 16'h5678, 16'hABCD, 16'h8000};
   logic [P_W-1:0]   st_p [4] = '{32'hFFFE_0001, 32'h0626_0060, 32'h0000_0000, 32'h0000_8000};

   logic [TAG_W+P_W-1:0] sb [$];
   logic [TAG_W+P_W-1:0] exp_e;
   logic                 prev_stall;
   logic [P_W-1:0]       prev_prod;
   int unsigned          ntag;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
      in_tag = '0; out_ready = 1'b1;

      // Reset state
      tick(); tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_product", 64'(out_product), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Single op: 0xFF * 0xFF
      run_single("single_ff", 16'h00FF, 16'h00FF, 1'b0, 4'd3, 32'h0000_FE01);

      // Back-to-back stream of four ops, results on cycles 3..6
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            in_valid = 1'b1; in_a = st_a[i]; in_b = st_b[i]; in_tag = TAG_W'(i + 1);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check("stream_in_ready", 64'(in_ready), 64'd1);
         tick();
         if (i >= 2 && i < 6) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_prod", 64'(out_product), 64'(st_p[i-2]));
            check("stream_tag", 64'(out_tag), 64'(i - 1));
         end else begin
            check("stream_idle", 64'(out_valid), 64'd0);
         end
      end

      // Backpressure: stall 5 cycles once first result is valid
      in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0100; in_tag = 4'd5; tick();
      in_a = 16'h0003; in_b = 16'h0005; in_tag = 4'd6; tick();
      in_a = 16'h8000; in_b = 16'h8000; in_tag = 4'd7; tick();
      in_a = 16'hABCD; in_b = 16'h0001; in_tag = 4'd8; out_ready = 1'b0;
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_prod", 64'(out_product), 64'h0000_FF00);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold_valid", 64'(out_valid), 64'd1);
         check("bp_hold_prod", 64'(out_product), 64'h0000_FF00);
         check("bp_hold_tag", 64'(out_tag), 64'd5);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("bp_r1_prod", 64'(out_product), 64'h0000_000F);
      check("bp_r1_tag", 64'(out_tag), 64'd6);
      tick();
      check("bp_r2_prod", 64'(out_product), 64'h4000_0000);
      check("bp_r2_tag", 64'(out_tag), 64'd7);
      tick();
      check("bp_r3_valid", 64'(out_valid), 64'd1);
      check("bp_r3_prod", 64'(out_product), 64'h0000_ABCD);
      check("bp_r3_tag", 64'(out_tag), 64'd8);
      tick();
      check("bp_no_dup", 64'(out_valid), 64'd0);

      // Asynchronous reset with three ops in flight
      in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h0003; in_tag = 4'd9; tick();
      in_a = 16'h0100; in_b = 16'h0100; in_tag = 4'd10; tick();
      in_a = 16'h00FF; in_b = 16'h00FF; in_tag = 4'd11; tick();
      in_valid = 1'b0;
      check("mid_rst_pre_prod", 64'(out_product), 64'h0000_3333);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_prod", 64'(out_product), 64'd0);
      check("mid_rst_tag", 64'(out_tag), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mid_rst_no_stale", 64'(out_valid), 64'd0);
      end

`ifdef VEDIC_SIGNED_EN
      run_single("s_min_min", 16'h8000, 16'h8000, 1'b1, 4'd1, 32'h4000_0000);
      run_single("s_m1_x2", 16'hFFFF, 16'h0002, 1'b1, 4'd2, 32'hFFFF_FFFE);
      run_single("u_ffff_x2", 16'hFFFF, 16'h0002, 1'b0, 4'd3, 32'h0001_FFFE);
      run_single("s_m3_x5", 16'hFFFD, 16'h0005, 1'b1, 4'd4, 32'hFFFF_FFF1);
`endif

      // Randomized valid/ready stream against an in-order queue model
      in_signed = 1'b0;
      ntag = 0;
      prev_stall = 1'b0;
      prev_prod = '0;
      for (int c = 0; c < 420; c++) begin
         in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
         out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
         in_a      = WIDTH'($urandom);
         in_b      = WIDTH'($urandom);
         in_tag    = TAG_W'(ntag);
         #1;
         if (prev_stall) begin
            check("rand_hold_valid", 64'(out_valid), 64'd1);
            check("rand_hold_prod", 64'(out_product), 64'(prev_prod));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("rand_spurious", 64'(out_valid), 64'd0);
            end else begin
               exp_e = sb.pop_front();
               check("rand_prod", 64'(out_product), 64'(exp_e[P_W-1:0]));
               check("rand_tag", 64'(out_tag), 64'(exp_e[TAG_W+P_W-1:P_W]));
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back({in_tag, P_W'(in_a) * P_W'(in_b)});
            ntag++;
         end
         prev_stall = out_valid && !out_ready;
         prev_prod  = out_product;
         tick();
      end
      check("rand_drain_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
